// File: rtl/uart_shift_unit.sv
// -----------------------------------------------------------------------------
// uart_shift_unit
//
// Bidirectional shift unit for the UART datapath. The same register serves
// receive (serial in, completed frame held on dout_o with a
// valid/ack/overrun handshake) and transmit (parallel load, serial out on
// sdo_o, with frame_done_o as the done indication).
//
// Parameters
//   WIDTH      frame length in bits, start and stop bits included (2..32)
//   LSB_FIRST  1: shift toward bit 0 (UART order); 0: shift toward bit WIDTH-1
//   RESET_VAL  contents of data_o after reset or clear_i
//
// Ports
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous clear of shift state and flags (dout_o is kept)
//   load_i        parallel load of load_data_i; count returns to 0
//   load_data_i   parallel word for transmit
//   shift_i       bit-time strobe, one bit per asserted cycle
//   sdi_i         serial data in
//   sdo_o         serial data out (data_o[0] or data_o[WIDTH-1])
//   data_o        live shift register contents
//   count_o       bits shifted so far in the current frame
//   dout_o        last completed frame, held
//   dout_valid_o  dout_o holds an unacknowledged frame
//   rd_ack_i      consumer acknowledge
//   frame_done_o  one-cycle pulse on the frame-completing shift
//   overrun_o     sticky: a frame completed while the previous was unread
// -----------------------------------------------------------------------------
module uart_shift_unit #(
   parameter int unsigned            WIDTH     = 10,
   parameter bit                     LSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic                      load_i,
   input  logic [WIDTH-1:0]          load_data_i,
   input  logic                      shift_i,
   input  logic                      sdi_i,
   output logic                      sdo_o,
   output logic [WIDTH-1:0]          data_o,
   output logic [$clog2(WIDTH)-1:0]  count_o,
   output logic [WIDTH-1:0]          dout_o,
   output logic                      dout_valid_o,
   input  logic                      rd_ack_i,
   output logic                      frame_done_o,
   output logic                      overrun_o
);

   localparam int unsigned       CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] shifted;

   // Shift direction is fixed at elaboration; sdo taps the bit that leaves next.
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign shifted = {sdi_i, data_q[WIDTH-1:1]};
         assign sdo_o   = data_q[0];
      end else begin : g_msb_first
         assign shifted = {data_q[WIDTH-2:0], sdi_i};
         assign sdo_o   = data_q[WIDTH-1];
      end
   endgenerate

   always_comb begin
      data_d       = data_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;

      if (clear_i) begin
         // dout is deliberately kept so software can still read the last frame.
         data_d       = RESET_VAL;
         count_d      = '0;
         dout_valid_d = 1'b0;
         overrun_d    = 1'b0;
      end else begin
         // Acknowledge first; a completing shift below overrides it so that a
         // new frame arriving on the ack edge stays valid.
         if (rd_ack_i) begin
            dout_valid_d = 1'b0;
         end

         if (load_i) begin
            data_d  = load_data_i;
            count_d = '0;
         end else if (shift_i) begin
            data_d = shifted;
            if (count_q == LAST) begin
               count_d      = '0;
               dout_d       = shifted;
               dout_valid_d = 1'b1;
               frame_done_d = 1'b1;
               if (dout_valid_q && !rd_ack_i) begin
                  overrun_d = 1'b1;
               end
            end else begin
               count_d = count_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q       <= RESET_VAL;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         data_q       <= data_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_o       = data_q;
   assign count_o      = count_q;
   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign frame_done_o = frame_done_q;
   assign overrun_o    = overrun_q;

endmodule
